dmem_access_arbiter: RTL

Sequencing controller and two-port arbiter for the single-ported data memory. It shares that memory between the CPU load/store stage (requester 0) and the DMA/debug port (requester 1) and inserts the memory's fixed access latency. It also drives the write-back select that chooses between memory data and the ALU result in the write-back stage. It sits between the MEM pipeline stage, the DMA engine and the data memory macro.

---
 rtl/dmem_access_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_access_arbiter
//
// Shares the single-ported data memory between the CPU load/store stage
// (requester 0) and the DMA/debug port (requester 1). Each granted access
// holds the memory enable for MEM_LAT cycles. The arbiter then spends one
// DONE cycle that pulses the grantee's ack, presents the read data and
// drives the write-back select.
//
// Sequence per access (cycle 0 = request seen in IDLE):
//   cycle 0              IDLE   : arbitrate and latch we/addr/wdata
//   cycles 1..MEM_LAT    ACCESS : out_mem_en = 1
//   cycle MEM_LAT+1      DONE   : ack pulse, out_rdata valid, wb select
//   cycle MEM_LAT+2      IDLE   : next request may be sampled
//
// Ports
//   in_clk, in_rst_n          clock, asynchronous active-low reset
//   in_req0/1, in_we0/1       request and write flag, CPU / DMA
//   in_addr0/1, in_wdata0/1   byte address and write data, CPU / DMA
//   out_ack0/1                one-cycle completion pulse to the grantee
//   out_rdata                 read data; valid in the ack cycle of a read
//   out_mem_en, out_mem_we    memory enable and qualified write enable
//   out_mem_addr/wdata        latched address / write data of the access
//   in_mem_rdata              memory read data, valid at the end of the
//                             last enable cycle
//   out_wb_select             1 = memory data to write-back, 0 = ALU result
//   out_busy                  high whenever the FSM is not in IDLE
//
// Every output comes straight from a flop. The output process therefore
// computes next-cycle values from the next state, and those values are
// registered.
// -----------------------------------------------------------------------------
module dmem_access_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_req0,
  input  logic        in_req1,
  input  logic        in_we0,
  input  logic        in_we1,
  input  logic [31:0] in_addr0,
  input  logic [31:0] in_addr1,
  input  logic [31:0] in_wdata0,
  input  logic [31:0] in_wdata1,
  output logic        out_ack0,
  output logic        out_ack1,
  output logic [31:0] out_rdata,
  output logic        out_mem_en,
  output logic        out_mem_we,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_wdata,
  input  logic [31:0] in_mem_rdata,
  output logic        out_wb_select,
  output logic        out_busy
);

  localparam int unsigned CNT_W = 4;

  if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_lat
    $error("dmem_access_arbiter: MEM_LAT must lie in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Round-robin pick. A tie goes to the requester that did not win last
  // time. A lone requester always wins. 0 = CPU, 1 = DMA.
  function automatic logic pick_grant(input logic req0, input logic req1,
                                      input logic last);
    logic g;
    if (req0 && req1) begin
      g = ~last;
    end else begin
      g = req1;
    end
    return g;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               gnt_q;
  logic               last_grant_q;
  logic               we_q;

  logic               any_req;
  logic               arb_gnt;
  logic               launch;
  logic               cnt_zero;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;

  logic               ack0_d;
  logic               ack1_d;
  logic [31:0]        rdata_d;
  logic               mem_en_d;
  logic               mem_we_d;
  logic [31:0]        mem_addr_d;
  logic [31:0]        mem_wdata_d;
  logic               wb_select_d;
  logic               busy_d;

  assign any_req   = in_req0 | in_req1;
  assign arb_gnt   = pick_grant(in_req0, in_req1, last_grant_q);
  assign launch    = (state_q == IDLE) && any_req;
  assign cnt_zero  = (cnt_q == '0);
  assign sel_we    = arb_gnt ? in_we1    : in_we0;
  assign sel_addr  = arb_gnt ? in_addr1  : in_addr0;
  assign sel_wdata = arb_gnt ? in_wdata1 : in_wdata0;

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)  state_d = ACCESS;
      ACCESS:  if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, latency counter and latched direction of the access in flight
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
    end else if (launch) begin
      cnt_q        <= CNT_W'(MEM_LAT - 1);
      gnt_q        <= arb_gnt;
      last_grant_q <= arb_gnt;
      we_q         <= sel_we;
    end else if ((state_q == ACCESS) && !cnt_zero) begin
      cnt_q        <= cnt_q - 1'b1;
    end
  end

  // Output logic: next-cycle values of the registered outputs
  always_comb begin
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    wb_select_d = 1'b0;
    mem_en_d    = (state_d == ACCESS);
    mem_we_d    = 1'b0;
    busy_d      = (state_d != IDLE);
    rdata_d     = out_rdata;
    mem_addr_d  = out_mem_addr;
    mem_wdata_d = out_mem_wdata;

    if (launch) begin
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_we_d    = sel_we;
    end else if (state_d == ACCESS) begin
      mem_we_d    = we_q;
    end

    // Memory data is only valid at the end of the last enable cycle.
    if ((state_q == ACCESS) && cnt_zero && !we_q) begin
      rdata_d = in_mem_rdata;
    end

    // DONE is only entered from ACCESS, so gnt_q/we_q describe this access.
    if (state_d == DONE) begin
      ack0_d      = ~gnt_q;
      ack1_d      = gnt_q;
      wb_select_d = ~gnt_q & ~we_q;
    end
  end

  // Output registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_ack0      <= 1'b0;
      out_ack1      <= 1'b0;
      out_rdata     <= '0;
      out_mem_en    <= 1'b0;
      out_mem_we    <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
      out_wb_select <= 1'b0;
      out_busy      <= 1'b0;
    end else begin
      out_ack0      <= ack0_d;
      out_ack1      <= ack1_d;
      out_rdata     <= rdata_d;
      out_mem_en    <= mem_en_d;
      out_mem_we    <= mem_we_d;
      out_mem_addr  <= mem_addr_d;
      out_mem_wdata <= mem_wdata_d;
      out_wb_select <= wb_select_d;
      out_busy      <= busy_d;
    end
  end

endmodule
